// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller drives the enables and selects; the datapath returns the IR fields and status.
interface multicycle_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       pcen;
   logic       illegal_op;

   modport master (
      input  op, funct, zero, mem_ready,
      output iord, memwrite, irwrite, regwrite, regdst, memtoreg,
             alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal_op
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  iord, memwrite, irwrite, regwrite, regdst, memtoreg,
             alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal_op
   );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode, execute,
// memory and writeback over a shared ALU and a single variable-latency memory port.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR and PC+4 when memory is ready
// DECODE   | branch target into ALUOut, dispatch on op
// MEMADR   | compute lw/sw effective address
// MEMRD    | read data memory, wait for mem_ready
// MEMWB    | write loaded data into rt
// MEMWR    | write data memory, wait for mem_ready
// RTYPEEX  | rs op rt, ALU op decoded from funct
// RTYPEWB  | write ALUOut into rd
// BEQEX    | compare rs/rt, load branch target when equal
// ADDIEX   | rs + SignImm
// ADDIWB   | write ALUOut into rt
// JEX      | load jump target
module multicycle_controller #(
   parameter int STATE_W       = 4,
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   multicycle_controller_if.master    bus,
   output logic [STATE_W-1:0]         state_o
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = STATE_W'(0),
      S_DECODE  = STATE_W'(1),
      S_MEMADR  = STATE_W'(2),
      S_MEMRD   = STATE_W'(3),
      S_MEMWB   = STATE_W'(4),
      S_MEMWR   = STATE_W'(5),
      S_RTYPEEX = STATE_W'(6),
      S_RTYPEWB = STATE_W'(7),
      S_BEQEX   = STATE_W'(8),
      S_ADDIEX  = STATE_W'(9),
      S_ADDIWB  = STATE_W'(10),
      S_JEX     = STATE_W'(11)
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state_q, state_d;
   logic       run_q;
   logic       is_sw_q;
   logic [2:0] alu_q;
   logic       mem_rdy;
   logic [2:0] rt_alu;
   logic       rt_ok;

   assign mem_rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;
   assign state_o = state_q;

   always_comb begin
      rt_alu = ALU_ADD;
      rt_ok  = 1'b1;
      unique case (bus.funct)
         6'b100000: rt_alu = ALU_ADD;
         6'b100010: rt_alu = ALU_SUB;
         6'b100100: rt_alu = ALU_AND;
         6'b100101: rt_alu = ALU_OR;
         6'b101010: rt_alu = ALU_SLT;
         default:   rt_ok  = 1'b0;
      endcase
   end

   // run_q holds off the first fetch until one full clock edge has passed after reset release
   always_comb begin
      state_d        = S_FETCH;
      bus.iord       = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regwrite   = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.alucontrol = ALU_ADD;
      bus.pcen       = 1'b0;
      bus.illegal_op = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            bus.alusrcb = 2'b01;
            bus.irwrite = run_q & mem_rdy;
            bus.pcen    = run_q & mem_rdy;
            state_d     = (run_q && mem_rdy) ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            bus.alusrcb = 2'b11;
            unique case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYP:      state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               default:      bus.illegal_op = 1'b1;
            endcase
         end
         S_MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            state_d     = is_sw_q ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            bus.iord = 1'b1;
            state_d  = mem_rdy ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
         end
         S_MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
            state_d      = mem_rdy ? S_FETCH : S_MEMWR;
         end
         S_RTYPEEX: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = rt_alu;
            bus.illegal_op = ~rt_ok;
            state_d        = rt_ok ? S_RTYPEWB : S_FETCH;
         end
         S_RTYPEWB: begin
            bus.regdst     = 1'b1;
            bus.regwrite   = 1'b1;
            bus.alucontrol = alu_q;
         end
         S_BEQEX: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = ALU_SUB;
            bus.pcsrc      = 2'b01;
            bus.pcen       = bus.zero;
         end
         S_ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            bus.regwrite = 1'b1;
         end
         S_JEX: begin
            bus.pcsrc = 2'b10;
            bus.pcen  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
         is_sw_q <= 1'b0;
         alu_q   <= ALU_ADD;
      end else begin
         run_q   <= 1'b1;
         state_q <= state_d;
         if (state_q == S_DECODE) is_sw_q <= (bus.op == OP_SW);
         if (state_q == S_RTYPEEX) alu_q <= rt_alu;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: stimulus pushes the expected
// per-cycle control word into a queue, a negedge monitor pops and compares.
module tb_multicycle_controller;

   typedef struct {
      logic [19:0] exp;
      string       name;
   } item_t;

   logic       clk;
   logic       rst;
   logic [3:0] state_o;
   int         checks;
   int         errors;
   item_t      exp_q[$];

   multicycle_controller_if bus ();

   multicycle_controller #(.STATE_W(4), .USE_MEM_READY(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.master),
      .state_o (state_o)
   );

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // layout: state, {iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca}, alusrcb, pcsrc, alucontrol, pcen, illegal_op
   function automatic logic [19:0] mk(input logic [3:0] st, input logic [6:0] fl,
                                      input logic [1:0] sb, input logic [1:0] pc,
                                      input logic [2:0] alu, input logic pe, input logic il);
      return {st, fl, sb, pc, alu, pe, il};
   endfunction

   task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic rdy, input logic [19:0] e, input string nm);
      item_t it;
      @(posedge clk);
      #1;
      rst           = r;
      bus.op        = o;
      bus.funct     = f;
      bus.zero      = z;
      bus.mem_ready = rdy;
      it.exp  = e;
      it.name = nm;
      exp_q.push_back(it);
   endtask

   initial begin : monitor
      item_t       it;
      logic [19:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            it  = exp_q.pop_front();
            act = {state_o, bus.iord, bus.memwrite, bus.irwrite, bus.regwrite, bus.regdst,
                   bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol,
                   bus.pcen, bus.illegal_op};
            checks++;
            if (act !== it.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [19:0] rstv, fet, fetw, dec, decill, madr, mrd, mwb, mwr;
      logic [19:0] rslt, wslt, rsub, wsub, rill, beq1, beq0, aex, awb, jex;
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.op = 6'd0;
      bus.funct = 6'd0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;

      rstv   = mk(4'd0,  7'b0000000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
      fet    = mk(4'd0,  7'b0010000, 2'b01, 2'b00, 3'b010, 1'b1, 1'b0);
      fetw   = mk(4'd0,  7'b0000000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
      dec    = mk(4'd1,  7'b0000000, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0);
      decill = mk(4'd1,  7'b0000000, 2'b11, 2'b00, 3'b010, 1'b0, 1'b1);
      madr   = mk(4'd2,  7'b0000001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
      mrd    = mk(4'd3,  7'b1000000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
      mwb    = mk(4'd4,  7'b0001010, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
      mwr    = mk(4'd5,  7'b1100000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
      rslt   = mk(4'd6,  7'b0000001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0);
      wslt   = mk(4'd7,  7'b0001100, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0);
      rsub   = mk(4'd6,  7'b0000001, 2'b00, 2'b00, 3'b110, 1'b0, 1'b0);
      wsub   = mk(4'd7,  7'b0001100, 2'b00, 2'b00, 3'b110, 1'b0, 1'b0);
      rill   = mk(4'd6,  7'b0000001, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1);
      beq1   = mk(4'd8,  7'b0000001, 2'b00, 2'b01, 3'b110, 1'b1, 1'b0);
      beq0   = mk(4'd8,  7'b0000001, 2'b00, 2'b01, 3'b110, 1'b0, 1'b0);
      aex    = mk(4'd9,  7'b0000001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
      awb    = mk(4'd10, 7'b0001000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
      jex    = mk(4'd11, 7'b0000000, 2'b00, 2'b10, 3'b010, 1'b1, 1'b0);

      step(1'b0, RT, 6'd0, 1'b0, 1'b1, rstv, "reset_hold0");
      step(1'b0, RT, 6'd0, 1'b0, 1'b1, rstv, "reset_hold1");
      step(1'b1, RT, 6'd0, 1'b0, 1'b1, rstv, "reset_release");

      step(1'b1, LW, 6'd0, 1'b0, 1'b1, fet,  "lw_fetch");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, dec,  "lw_decode");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, madr, "lw_memadr");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, mrd,  "lw_memrd");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, mwb,  "lw_memwb");

      step(1'b1, SW, 6'd0, 1'b0, 1'b1, fet,  "sw_fetch");
      step(1'b1, SW, 6'd0, 1'b0, 1'b1, dec,  "sw_decode");
      step(1'b1, SW, 6'd0, 1'b0, 1'b1, madr, "sw_memadr");
      step(1'b1, SW, 6'd0, 1'b0, 1'b0, mwr,  "sw_memwr_wait0");
      step(1'b1, SW, 6'd0, 1'b0, 1'b0, mwr,  "sw_memwr_wait1");
      step(1'b1, SW, 6'd0, 1'b0, 1'b1, mwr,  "sw_memwr_done");

      step(1'b1, ADDI, 6'd0, 1'b0, 1'b0, fetw, "addi_fetch_wait");
      step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, fet,  "addi_fetch");
      step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, dec,  "addi_decode");
      step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, aex,  "addi_ex");
      step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, awb,  "addi_wb");

      step(1'b1, RT, 6'b101010, 1'b0, 1'b1, fet,  "slt_fetch");
      step(1'b1, RT, 6'b101010, 1'b0, 1'b1, dec,  "slt_decode");
      step(1'b1, RT, 6'b101010, 1'b0, 1'b1, rslt, "slt_ex");
      step(1'b1, RT, 6'b101010, 1'b0, 1'b1, wslt, "slt_wb");

      step(1'b1, RT, 6'b100010, 1'b0, 1'b1, fet,  "sub_fetch");
      step(1'b1, RT, 6'b100010, 1'b0, 1'b1, dec,  "sub_decode");
      step(1'b1, RT, 6'b100010, 1'b0, 1'b1, rsub, "sub_ex");
      step(1'b1, RT, 6'b100010, 1'b0, 1'b1, wsub, "sub_wb");

      step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, fet,  "beq1_fetch");
      step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, dec,  "beq1_decode");
      step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, beq1, "beq1_ex_taken");
      step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, fet,  "beq0_fetch");
      step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, dec,  "beq0_decode");
      step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, beq0, "beq0_ex_not_taken");

      step(1'b1, JMP, 6'd0, 1'b0, 1'b1, fet, "j_fetch");
      step(1'b1, JMP, 6'd0, 1'b0, 1'b1, dec, "j_decode");
      step(1'b1, JMP, 6'd0, 1'b0, 1'b1, jex, "j_ex");

      step(1'b1, BAD, 6'd0, 1'b0, 1'b1, fet,    "badop_fetch");
      step(1'b1, BAD, 6'd0, 1'b0, 1'b1, decill, "badop_decode");
      step(1'b1, RT,  6'd0, 1'b0, 1'b1, fet,    "badfunct_fetch");
      step(1'b1, RT,  6'd0, 1'b0, 1'b1, dec,    "badfunct_decode");
      step(1'b1, RT,  6'd0, 1'b0, 1'b1, rill,   "badfunct_ex");

      step(1'b1, LW, 6'd0, 1'b0, 1'b1, fet,  "lwwait_fetch");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, dec,  "lwwait_decode");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, madr, "lwwait_memadr");
      step(1'b1, LW, 6'd0, 1'b0, 1'b0, mrd,  "lwwait_memrd_wait");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, mrd,  "lwwait_memrd_done");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, mwb,  "lwwait_memwb");

      step(1'b1, SW, 6'd0, 1'b0, 1'b1, fet,  "swrst_fetch");
      step(1'b1, SW, 6'd0, 1'b0, 1'b1, dec,  "swrst_decode");
      step(1'b1, SW, 6'd0, 1'b0, 1'b1, madr, "swrst_memadr");
      step(1'b1, SW, 6'd0, 1'b0, 1'b0, mwr,  "swrst_memwr");
      step(1'b0, SW, 6'd0, 1'b0, 1'b0, rstv, "swrst_async_reset");
      step(1'b0, SW, 6'd0, 1'b0, 1'b1, rstv, "swrst_hold1");
      step(1'b0, SW, 6'd0, 1'b0, 1'b1, rstv, "swrst_hold2");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, rstv, "swrst_release");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, fet,  "post_fetch");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, dec,  "post_decode");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, madr, "post_memadr");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, mrd,  "post_memrd");
      step(1'b1, LW, 6'd0, 1'b0, 1'b1, mwb,  "post_memwb");
      step(1'b1, LW, 6'd0, 1'b0, 1'b0, fetw, "post_fetch_idle");

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
